// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite/bullet compositing path.
// Pixel colours travel as packed {R,G,B} bytes.
package sprite_pkg;

    localparam int DEF_COORD_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        BLEND_PRIORITY = 1'b0,
        BLEND_ADD      = 1'b1
    } blend_e;

    function automatic logic [7:0] sat_add8(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/bullet_span_check.sv
// Combinational test of whether the current pixel lies on one bullet.
// The bullet is a vertical run of BULLET_LEN pixels from its top coordinate.
module bullet_span_check #(
    parameter int COORD_W    = 10,
    parameter int BULLET_LEN = 4
) (
    input  logic               valid_i,
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] draw_y_i,
    input  logic [COORD_W-1:0] bul_x_i,
    input  logic [COORD_W-1:0] bul_y_i,
    output logic               span_o
);

    logic [COORD_W-1:0] dy;

    // Unsigned modular distance: rows above the bullet wrap to large values.
    always_comb begin
        dy     = draw_y_i - bul_y_i;
        span_o = valid_i
              && (draw_x_i == bul_x_i)
              && (dy < COORD_W'(BULLET_LEN));
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: bullets over prioritised or additive layers.
// Also gathers per-bullet enemy collisions and publishes them once per frame.
module layer_compositor
    import sprite_pkg::*;
#(
    parameter int          COORD_W     = DEF_COORD_W,
    parameter int          NUM_LAYERS  = 4,
    parameter int          NUM_BULLETS = 4,
    parameter int          BULLET_LEN  = 4,
    parameter int          ENEMY_LAYER = 1,
    parameter logic [23:0] BULLET_RGB  = 24'hFFFFFF
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           pix_valid,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             DrawX,
    input  logic [COORD_W-1:0]             DrawY,
    input  logic [NUM_BULLETS-1:0]         bullet_valid,
    input  logic [NUM_BULLETS*COORD_W-1:0] bulletX,
    input  logic [NUM_BULLETS*COORD_W-1:0] bulletY,
    input  logic [NUM_LAYERS-1:0]          layer_on,
    input  logic [NUM_LAYERS*24-1:0]       layer_rgb,
    input  logic [23:0]                    bg_rgb,
    input  logic                           blend_mode,
    output logic [7:0]                     Red,
    output logic [7:0]                     Green,
    output logic [7:0]                     Blue,
    output logic [COORD_W-1:0]             OutX,
    output logic [COORD_W-1:0]             OutY,
    output logic                           out_valid,
    output logic [NUM_BULLETS-1:0]         hit_mask,
    output logic                           hit_strobe
);

    localparam int ACC_W = 8 + $clog2(NUM_LAYERS);

    function automatic logic [7:0] clamp8(input logic [ACC_W-1:0] v);
        return (v > ACC_W'(255)) ? 8'hFF : v[7:0];
    endfunction

    // Stage 0: per-bullet span and collision vectors
    logic [NUM_BULLETS-1:0] span;
    logic [NUM_BULLETS-1:0] coll;

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_span
        bullet_span_check #(
            .COORD_W    (COORD_W),
            .BULLET_LEN (BULLET_LEN)
        ) u_span (
            .valid_i  (bullet_valid[i]),
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .bul_x_i  (bulletX[i*COORD_W +: COORD_W]),
            .bul_y_i  (bulletY[i*COORD_W +: COORD_W]),
            .span_o   (span[i])
        );
    end

    assign coll = span & {NUM_BULLETS{layer_on[ENEMY_LAYER]}};

    // Stage 1 registers
    logic [NUM_BULLETS-1:0]   s1_span_q;
    logic [NUM_LAYERS-1:0]    s1_on_q;
    logic [NUM_LAYERS*24-1:0] s1_rgb_q;
    rgb_t                     s1_bg_q;
    blend_e                   s1_mode_q;
    logic [COORD_W-1:0]       s1_x_q;
    logic [COORD_W-1:0]       s1_y_q;
    logic                     s1_vld_q;

    // Capture the raw pixel context on each strobe
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s1_span_q <= '0;
            s1_on_q   <= '0;
            s1_rgb_q  <= '0;
            s1_bg_q   <= '0;
            s1_mode_q <= BLEND_PRIORITY;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_vld_q  <= 1'b0;
        end else if (pix_valid) begin
            s1_span_q <= span;
            s1_on_q   <= layer_on;
            s1_rgb_q  <= layer_rgb;
            s1_bg_q   <= rgb_t'(bg_rgb);
            s1_mode_q <= blend_e'(blend_mode);
            s1_x_q    <= DrawX;
            s1_y_q    <= DrawY;
            s1_vld_q  <= 1'b1;
        end
    end

    // Stage 2 colour resolution
    rgb_t             pri_rgb;
    rgb_t             add_rgb;
    rgb_t             lay;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_g;
    logic [ACC_W-1:0] acc_b;
    rgb_t             pix_d;

    // Walk layers high-to-low so the lowest enabled index wins priority
    always_comb begin
        pri_rgb = s1_bg_q;
        lay     = '0;
        acc_r   = '0;
        acc_g   = '0;
        acc_b   = '0;
        for (int j = NUM_LAYERS - 1; j >= 0; j--) begin
            lay = rgb_t'(s1_rgb_q[j*24 +: 24]);
            if (s1_on_q[j]) begin
                pri_rgb = lay;
                acc_r   = acc_r + ACC_W'(lay.r);
                acc_g   = acc_g + ACC_W'(lay.g);
                acc_b   = acc_b + ACC_W'(lay.b);
            end
        end
        add_rgb.r = clamp8(acc_r);
        add_rgb.g = clamp8(acc_g);
        add_rgb.b = clamp8(acc_b);
    end

    // Bullets override layers; layers override background
    always_comb begin
        pix_d = s1_bg_q;
        if (|s1_span_q) begin
            pix_d = rgb_t'(BULLET_RGB);
        end else if (|s1_on_q) begin
            pix_d = (s1_mode_q == BLEND_ADD) ? add_rgb : pri_rgb;
        end
    end

    // Stage 2 registers
    rgb_t               pix_q;
    logic [COORD_W-1:0] outx_q;
    logic [COORD_W-1:0] outy_q;
    logic               ov_q;

    // Output register stage, advanced only on strobes
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pix_q  <= '0;
            outx_q <= '0;
            outy_q <= '0;
            ov_q   <= 1'b0;
        end else if (pix_valid) begin
            pix_q  <= pix_d;
            outx_q <= s1_x_q;
            outy_q <= s1_y_q;
            ov_q   <= s1_vld_q;
        end
    end

    // Collision tracking
    logic [NUM_BULLETS-1:0] live_q, live_d;
    logic [NUM_BULLETS-1:0] mask_q, mask_d;
    logic                   strobe_q, strobe_d;

    // Pixel (0,0) opens the new frame, so its hits seed the fresh set
    always_comb begin
        live_d   = live_q;
        mask_d   = mask_q;
        strobe_d = 1'b0;
        if (pix_valid) begin
            if (frame_start) begin
                mask_d   = live_q;
                live_d   = coll;
                strobe_d = |live_q;
            end else begin
                live_d = live_q | coll;
            end
        end
    end

    // Collision state registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            live_q   <= '0;
            mask_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            live_q   <= live_d;
            mask_q   <= mask_d;
            strobe_q <= strobe_d;
        end
    end

    assign Red        = pix_q.r;
    assign Green      = pix_q.g;
    assign Blue       = pix_q.b;
    assign OutX       = outx_q;
    assign OutY       = outy_q;
    assign out_valid  = ov_q;
    assign hit_mask   = mask_q;
    assign hit_strobe = strobe_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor.
// Directed scenarios followed by random pixels against a frame-level model.
module tb_layer_compositor;

    localparam int          CW    = 10;
    localparam int          NL    = 4;
    localparam int          NB    = 4;
    localparam int          BLEN  = 4;
    localparam int          ENEMY = 1;
    localparam logic [23:0] BRGB  = 24'hFFFFFF;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             pix_valid;
    logic             frame_start;
    logic [CW-1:0]    DrawX, DrawY;
    logic [NB-1:0]    bullet_valid;
    logic [NB*CW-1:0] bulletX, bulletY;
    logic [NL-1:0]    layer_on;
    logic [NL*24-1:0] layer_rgb;
    logic [23:0]      bg_rgb;
    logic             blend_mode;
    logic [7:0]       Red, Green, Blue;
    logic [CW-1:0]    OutX, OutY;
    logic             out_valid;
    logic [NB-1:0]    hit_mask;
    logic             hit_strobe;

    layer_compositor #(
        .COORD_W     (CW),
        .NUM_LAYERS  (NL),
        .NUM_BULLETS (NB),
        .BULLET_LEN  (BLEN),
        .ENEMY_LAYER (ENEMY),
        .BULLET_RGB  (BRGB)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .bullet_valid (bullet_valid),
        .bulletX      (bulletX),
        .bulletY      (bulletY),
        .layer_on     (layer_on),
        .layer_rgb    (layer_rgb),
        .bg_rgb       (bg_rgb),
        .blend_mode   (blend_mode),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .OutX         (OutX),
        .OutY         (OutY),
        .out_valid    (out_valid),
        .hit_mask     (hit_mask),
        .hit_strobe   (hit_strobe)
    );

    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: pixel waiting in the pipe and expected outputs
    logic [23:0]   p_rgb, e_rgb;
    logic [CW-1:0] p_x, p_y, e_x, e_y;
    logic          e_valid;
    int            n_str;
    logic [NB-1:0] m_live, e_mask;
    logic          e_strobe;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".rgb"}, 32'({Red, Green, Blue}), 32'(e_rgb));
        check({tag, ".x"}, 32'(OutX), 32'(e_x));
        check({tag, ".y"}, 32'(OutY), 32'(e_y));
        check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, ".mask"}, 32'(hit_mask), 32'(e_mask));
        check({tag, ".strobe"}, 32'(hit_strobe), 32'(e_strobe));
    endtask

    // Bullet i covers rows top..top+BLEN-1, counted modulo 2^CW
    function automatic logic [NB-1:0] model_span();
        logic [NB-1:0] s;
        for (int i = 0; i < NB; i++) begin
            int by, bx, d;
            bx = int'(bulletX[i*CW +: CW]);
            by = int'(bulletY[i*CW +: CW]);
            d  = (int'(DrawY) - by + 1024) % 1024;
            s[i] = bullet_valid[i] && (int'(DrawX) == bx) && (d < BLEN);
        end
        return s;
    endfunction

    function automatic logic [23:0] model_rgb(input logic [NB-1:0] sp);
        int r, g, b;
        if (sp != 0) return BRGB;
        if (layer_on == 0) return bg_rgb;
        if (!blend_mode) begin
            for (int j = 0; j < NL; j++)
                if (layer_on[j]) return layer_rgb[j*24 +: 24];
        end
        r = 0; g = 0; b = 0;
        for (int j = 0; j < NL; j++) begin
            if (layer_on[j]) begin
                r += int'(layer_rgb[j*24+16 +: 8]);
                g += int'(layer_rgb[j*24+8 +: 8]);
                b += int'(layer_rgb[j*24 +: 8]);
            end
        end
        if (r > 255) r = 255;
        if (g > 255) g = 255;
        if (b > 255) b = 255;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic strobe(input logic fs);
        logic [NB-1:0] sp, cv;
        logic [23:0]   c;
        sp = model_span();
        c  = model_rgb(sp);
        cv = sp & {NB{layer_on[ENEMY]}};
        frame_start = fs;
        pix_valid   = 1'b1;
        @(posedge Clk);
        #1;
        n_str++;
        e_rgb   = p_rgb;
        e_x     = p_x;
        e_y     = p_y;
        e_valid = (n_str >= 2);
        p_rgb   = c;
        p_x     = DrawX;
        p_y     = DrawY;
        if (fs) begin
            e_mask   = m_live;
            e_strobe = |m_live;
            m_live   = cv;
        end else begin
            m_live   = m_live | cv;
            e_strobe = 1'b0;
        end
        check_outs("strobe");
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle();
        frame_start = 1'($urandom);
        DrawX       = CW'($urandom_range(0, 7));
        @(posedge Clk);
        #1;
        e_strobe = 1'b0;
        check_outs("hold");
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        Reset       = 1'b0;
        pix_valid   = 1'b1;
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        p_rgb = '0; p_x = '0; p_y = '0;
        e_rgb = '0; e_x = '0; e_y = '0;
        e_valid = 1'b0; e_mask = '0; e_strobe = 1'b0;
        m_live = '0; n_str = 0;
        check_outs("reset");
        Reset       = 1'b1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic clear_all();
        bullet_valid = '0;
        bulletX      = '0;
        bulletY      = '0;
        layer_on     = '0;
        layer_rgb    = '0;
        blend_mode   = 1'b0;
    endtask

    task automatic set_bullet(input int i, input logic v,
                              input int x, input int y);
        bullet_valid[i]       = v;
        bulletX[i*CW +: CW]   = CW'(x);
        bulletY[i*CW +: CW]   = CW'(y);
    endtask

    task automatic set_layer(input int j, input logic on,
                             input logic [23:0] rgb);
        layer_on[j]          = on;
        layer_rgb[j*24 +: 24] = rgb;
    endtask

    task automatic rand_inputs();
        DrawX = CW'($urandom_range(0, 7));
        DrawY = CW'($urandom_range(0, 7));
        for (int i = 0; i < NB; i++) begin
            int by;
            by = ($urandom_range(0, 9) == 0)
               ? 1020 + int'($urandom_range(0, 3))
               : int'($urandom_range(0, 7));
            set_bullet(i, $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 7)), by);
        end
        layer_on   = NL'($urandom);
        layer_rgb  = {$urandom, $urandom, $urandom};
        bg_rgb     = 24'($urandom);
        blend_mode = 1'($urandom);
    endtask

    initial begin
        Reset = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
        DrawX = '0; DrawY = '0; bg_rgb = '0;
        clear_all();
        repeat (2) @(posedge Clk);
        #1;
        do_reset();

        // Single bullet scan, including rows above the top (wrap check)
        bg_rgb = 24'h123456;
        set_bullet(0, 1'b1, 100, 50);
        for (int y = 48; y <= 55; y++) begin
            DrawX = CW'(100);
            DrawY = CW'(y);
            strobe(1'b0);
            if (y > 48) begin
                check("scan.rgb", 32'({Red, Green, Blue}),
                      (y - 1 >= 50 && y - 1 <= 53) ? 32'hFFFFFF
                                                   : 32'h123456);
                check("scan.y", 32'(OutY), 32'(y - 1));
            end
        end

        // Priority versus additive blend
        clear_all();
        set_layer(0, 1'b1, 24'h102030);
        set_layer(2, 1'b1, 24'hF0F0F0);
        DrawX = CW'(5); DrawY = CW'(5);
        strobe(1'b0);
        blend_mode = 1'b1;
        strobe(1'b0);
        check("prio", 32'({Red, Green, Blue}), 32'h102030);
        strobe(1'b0);
        check("add_sat", 32'({Red, Green, Blue}), 32'hFFFFFF);

        // Mid-frame collision by bullet 2, published at frame start
        clear_all();
        DrawX = '0; DrawY = '0;
        strobe(1'b1);
        set_bullet(2, 1'b1, 200, 100);
        set_layer(ENEMY, 1'b1, 24'h00FF00);
        DrawX = CW'(200); DrawY = CW'(101);
        strobe(1'b0);
        DrawY = CW'(102);
        strobe(1'b0);
        clear_all();
        DrawX = '0; DrawY = '0;
        strobe(1'b1);
        check("pub.mask", 32'(hit_mask), 32'h4);
        check("pub.strobe", 32'(hit_strobe), 32'h1);
        idle();
        DrawX = CW'(3);
        strobe(1'b0);
        DrawX = '0;
        strobe(1'b1);
        check("clean.mask", 32'(hit_mask), 32'h0);
        check("clean.strobe", 32'(hit_strobe), 32'h0);

        // Collision on pixel (0,0) belongs to the new frame
        set_bullet(1, 1'b1, 0, 0);
        set_layer(ENEMY, 1'b1, 24'h0000FF);
        strobe(1'b1);
        check("origin.mask0", 32'(hit_mask), 32'h0);
        clear_all();
        DrawX = CW'(9);
        strobe(1'b0);
        DrawX = '0;
        strobe(1'b1);
        check("origin.mask1", 32'(hit_mask), 32'h2);
        check("origin.strobe", 32'(hit_strobe), 32'h1);

        // Strobe gaps hold the pipeline
        DrawX = CW'(7); bg_rgb = 24'hABCDEF;
        strobe(1'b0);
        idle();
        idle();
        DrawX = CW'(8);
        strobe(1'b0);

        // Reset with a pending collision discards it
        set_bullet(3, 1'b1, 4, 4);
        set_layer(ENEMY, 1'b1, 24'h010101);
        DrawX = CW'(4); DrawY = CW'(5);
        strobe(1'b0);
        do_reset();
        clear_all();
        DrawX = '0; DrawY = '0;
        strobe(1'b1);
        check("rst.pub", 32'(hit_mask), 32'h0);

        // Random pixels with sparse frame starts, gaps and resets
        for (int k = 0; k < 600; k++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                strobe($urandom_range(0, 19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined pixel compositor that replaces the single-bullet combinational color mapper. It sits between the sprite/entity generators and the VGA output registers.
- Resolves NUM_BULLETS bullets plus NUM_LAYERS sprite layers into one RGB pixel per pixel strobe. Supports priority or saturating-additive blend.
- Accumulates per-bullet collisions against the enemy layer across a frame and publishes them at frame boundary.

Parameters:
- COORD_W, 10, width of DrawX/DrawY and bullet coordinates
- NUM_LAYERS, 4, number of sprite layers; index 0 is highest priority
- NUM_BULLETS, 4, number of independent bullet channels
- BULLET_LEN, 4, vertical bullet length in pixels, 1..15
- ENEMY_LAYER, 1, layer index used for collision detection, < NUM_LAYERS
- BULLET_RGB, 24'hFFFFFF, bullet colour

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- pix_valid  in  1  pixel strobe; the pipeline advances only when high
- frame_start  in  1  high with the pix_valid of pixel (0,0); sampled only when pix_valid=1
- DrawX, DrawY  in  COORD_W each  current pixel coordinates
- bullet_valid  in  NUM_BULLETS  bullet i active
- bulletX, bulletY  in  NUM_BULLETS*COORD_W each  packed bullet top coordinates, channel i at [i*COORD_W +: COORD_W]
- layer_on  in  NUM_LAYERS  layer j covers the current pixel
- layer_rgb  in  NUM_LAYERS*24  packed {R,G,B} per layer
- bg_rgb  in  24  background colour
- blend_mode  in  1  0 = priority, 1 = saturating additive
- Red, Green, Blue  out  8 each  composited pixel
- OutX, OutY  out  COORD_W each  coordinates aligned with Red/Green/Blue
- out_valid  out  1  output pixel is meaningful
- hit_mask  out  NUM_BULLETS  collisions from the previous complete frame
- hit_strobe  out  1  one-cycle pulse at frame publish when hit_mask != 0

Behaviour:
- Reset (Reset=0 at a Clk edge): Red/Green/Blue, OutX/OutY, out_valid, hit_mask, hit_strobe, the internal hit_live register and all pipeline registers go to 0. Reset dominates pix_valid and frame_start in the same cycle.
- Stage 0, combinational on the inputs:
  - span_i = bullet_valid[i] && DrawX==bulletX[i] && (DrawY - bulletY[i]) < BULLET_LEN.
  - The subtraction is unsigned COORD_W-bit, so DrawY < bulletY wraps to a large value and gives no hit. No signed or int arithmetic.
- Stage 1 register, loaded on pix_valid: span vector, layer_on, layer_rgb, bg_rgb, blend_mode, DrawX, DrawY.
- Stage 2 register, loaded on pix_valid: colour is chosen in this order.
  - Any span bit set: BULLET_RGB.
  - Else, blend_mode=0 and any layer on: rgb of the lowest-indexed layer that is on.
  - Else, blend_mode=1 and any layer on: per-channel sum of all on layers, saturated to 8'hFF. The accumulator is 8+clog2(NUM_LAYERS) bits wide.
  - Else: bg_rgb.
- Latency: a pixel presented on pix_valid strobe k appears on the outputs after strobe k+1. That is 2 strobes and 2 register stages.
- Stall: with pix_valid=0 all pipeline registers and outputs hold.
- out_valid: goes to 1 on the second pix_valid after reset and stays 1 until reset.
- Collision: on pix_valid, hit_live[i] |= span_i && layer_on[ENEMY_LAYER], evaluated on the Stage 0 inputs.
- Frame publish, on pix_valid && frame_start:
  - hit_mask <= hit_live.
  - hit_live <= the collision vector of the current pixel (0,0) only. The current pixel belongs to the new frame, so it is not lost and not double-counted.
  - hit_strobe <= |hit_live.
- hit_strobe is 0 in every other cycle. hit_mask holds until the next publish.
- Two collisions by the same bullet in one frame still set a single bit.
- Bullets overlapping each other render BULLET_RGB. Each bullet sets only its own hit bit.
- frame_start without pix_valid is ignored.

Decomposition:
- Package sprite_pkg:
  - rgb_t packed struct {R,G,B} of 8 bits each.
  - COORD_W default constant.
  - blend_e enum {BLEND_PRIORITY, BLEND_ADD}.
  - sat_add8 function.
- Sub-module bullet_span_check: one per bullet via generate; purely combinational span_i. The top level owns all registers.

Test Plan:
- Single bullet at (100,50), BULLET_LEN=4, no layers, scan DrawY 48..55 at DrawX=100 -> BULLET_RGB for Y=50..53 only, each appearing 2 strobes later with OutX/OutY matching. Y=48,49 give no hit (wrap check).
- Layers 0 and 2 on with 24'h102030 and 24'hF0F0F0, blend_mode=0 -> 24'h102030. blend_mode=1 -> 24'hFFFFFF (R 0x100 saturates, G 0x110, B 0x120 all clamp).
- Bullet 2 over an enemy pixel mid-frame, then frame_start -> hit_mask=4'b0100 and hit_strobe high exactly one cycle. The next frame has no collision -> hit_mask=0 after its frame_start, with no strobe.
- Collision on pixel (0,0) coincident with frame_start -> the published hit_mask excludes it and the following publish includes it.
- Toggle pix_valid 1-0-0-1 -> outputs hold during the low cycles and advance only on strobes.
- Reset asserted mid-frame with hit_live nonzero -> next cycle all outputs 0, and the subsequent publish is 0.
